seg_display_scheduler: RTL
==========================

Name: seg_display_scheduler

Overview:
- Shares one multiplexed NUM_DIGITS-digit seven-segment display among three requesters (e.g. score counter, note name, mode indicator).
- A round-robin arbiter with a minimum-hold lease decides which requester owns the display.
- A scan FSM time-multiplexes the digits, inserting a blanking gap between digits to suppress ghosting.
- Sits between the game/piano logic and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of display digits; digit index width is clog2(NUM_DIGITS).
- SCAN_DIV, 10000, clk cycles each digit is driven (SHOW phase length), at least 1.
- BLANK_CYCLES, 100, clk cycles all digits are off between digits (BLANK phase length), at least 1.
- HOLD_CYCLES, 5_000_000, minimum owner lease before a pending requester may pre-empt; counter is 32 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  3  per-requester display request, level-sensitive
- data0  in  4*NUM_DIGITS  requester 0 digit codes; nibble i drives digit i
- data1  in  4*NUM_DIGITS  requester 1 digit codes
- data2  in  4*NUM_DIGITS  requester 2 digit codes
- mask0/mask1/mask2  in  NUM_DIGITS  per-requester digit enable; 0 blanks that digit
- grant  out  3  one-hot current owner; 0 when idle
- seg  out  7  segments, active-high, bit0=a … bit6=g
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high
- frame_done  out  1  one-cycle pulse when the last digit's BLANK phase ends

Behaviour:
- Reset (async) values:
  - grant=0, seg=0, digit_sel=0, frame_done=0.
  - scan FSM in BLANK with index=NUM_DIGITS-1 and phase counter 0.
  - hold counter 0; round-robin pointer 0, so requester 0 has top priority first.
- Arbiter, evaluated every cycle, grant registered:
  - Idle and any req high: grant the first requester with req high, searching upward cyclically from the pointer. Grant is visible the next cycle; the pointer moves to owner+1 (mod 3).
  - Owner drops req: grant goes to 0 the next cycle; re-arbitration happens the cycle after.
  - Hold counter counts up from 0 each cycle a grant is held and saturates at HOLD_CYCLES.
  - When the hold counter equals HOLD_CYCLES and another req is high, grant moves directly to the next requester in round-robin order, with no idle cycle, and the hold counter clears.
  - With no competing request the owner keeps the grant indefinitely.
- Scan FSM, states SHOW and BLANK:
  - SHOW lasts exactly SCAN_DIV cycles, then goes to BLANK.
  - BLANK lasts exactly BLANK_CYCLES cycles, then goes to SHOW with index = index+1, wrapping NUM_DIGITS-1 to 0.
  - frame_done pulses on the last BLANK cycle when index=NUM_DIGITS-1.
- Outputs are registered and take their value on the first cycle of each phase:
  - BLANK: seg=0, digit_sel=0.
  - SHOW: digit_sel=1<<index. Owner, code and mask are sampled once at SHOW entry and held for the whole phase; grant changes mid-digit are not visible until the next digit.
  - Idle (grant=0) or mask bit 0: seg=0 while digit_sel still strobes.
- Digit decode:
  - 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
  - 0xA: 40 (dash).
  - 0xB..0xF: 00 (blank).
- Reset asserted mid-phase returns to the reset state immediately; no partial digit completes.

Optional Feature:
- Macro SEG_DIM_EN.
- When defined:
  - Adds input duty (4 bits).
  - During SHOW, digit_sel and seg are active only while the phase counter is below (SCAN_DIV*duty)>>4. The product is computed in 36 bits.
  - Outside that window both outputs are 0.
  - duty=0 means fully dark; duty=15 is the maximum.
- When undefined: the port is absent and SHOW drives for the full SCAN_DIV.

Test Plan:
- Reset mid-SHOW with NUM_DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1, HOLD_CYCLES=20 → seg=0, digit_sel=0, grant=0 during rst. Digit 0 is driven starting 2 cycles after release.
- req=001, data0=0x76543210, mask0=FF → grant=001 one cycle later. digit i shows code i (digit0=3F, digit7=07); digit_sel walks 01→80 with 1-cycle gaps; frame_done pulses every 40 cycles.
- req=011 held continuously from idle → grant=001, then 010 exactly 20 cycles after the grant edge, then 001 after another 20.
- Owner 0 drops req while req1 is low → grant=000 next cycle. seg=0 on subsequent digits while digit_sel keeps scanning.
- mask0=0xFE, data0 nibbles 0xA and 0xC → digit0 blank, dash = 40, 0xC digits = 00.
- With SEG_DIM_EN, SCAN_DIV=16, duty=4 → each digit is driven for 4 of its 16 SHOW cycles. With duty=0, digit_sel stays 0 for the whole frame.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin display lease plus blanked digit scan.
// Optional macro SEG_DIM_EN adds a 4-bit duty input for SHOW-phase dimming.
module seg_display_scheduler #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 10000,
   parameter int BLANK_CYCLES = 100,
   parameter int HOLD_CYCLES  = 5_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              req,
   input  logic [4*NUM_DIGITS-1:0] data0,
   input  logic [4*NUM_DIGITS-1:0] data1,
   input  logic [4*NUM_DIGITS-1:0] data2,
   input  logic [NUM_DIGITS-1:0]   mask0,
   input  logic [NUM_DIGITS-1:0]   mask1,
   input  logic [NUM_DIGITS-1:0]   mask2,
`ifdef SEG_DIM_EN
   input  logic [3:0]              duty,
`endif
   output logic [2:0]              grant,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [31:0] SHOW_LAST  = 32'(SCAN_DIV - 1);
   localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYCLES - 1);
   localparam logic [31:0] HOLD       = 32'(HOLD_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   typedef enum logic {SHOW, BLANK} state_t;

   function automatic logic [1:0] wrap3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // {found, index} of the first set bit searching cyclically from start
   function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                          input logic [1:0] start);
      logic [1:0] i;
      rr_pick = 3'b000;
      i = start;
      for (int k = 0; k < 3; k++) begin
         if (!rr_pick[2] && r[i]) rr_pick = {1'b1, i};
         i = wrap3(i);
      end
   endfunction

   function automatic logic [6:0] dec(input logic [3:0] c);
      case (c)
         4'h0: dec = 7'h3F;
         4'h1: dec = 7'h06;
         4'h2: dec = 7'h5B;
         4'h3: dec = 7'h4F;
         4'h4: dec = 7'h66;
         4'h5: dec = 7'h6D;
         4'h6: dec = 7'h7D;
         4'h7: dec = 7'h07;
         4'h8: dec = 7'h7F;
         4'h9: dec = 7'h6F;
         4'hA: dec = 7'h40;
         default: dec = 7'h00;
      endcase
   endfunction

   logic [1:0]  ptr;
   logic [31:0] hold;
   logic [31:0] hold_inc;
   logic [1:0]  owner;
   logic [1:0]  first_idx;
   logic [1:0]  next_idx;
   logic        first_ok;
   logic        next_ok;

   always_comb begin
      owner = 2'd0;
      unique case (1'b1)
         grant[1]: owner = 2'd1;
         grant[2]: owner = 2'd2;
         default:  owner = 2'd0;
      endcase
   end

   assign {first_ok, first_idx} = rr_pick(req, ptr);
   assign {next_ok, next_idx}   = rr_pick(req & ~grant, wrap3(owner));
   assign hold_inc = (hold >= HOLD) ? HOLD : hold + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant <= 3'b000;
         ptr   <= 2'd0;
         hold  <= '0;
      end else if (grant == 3'b000) begin
         hold <= '0;
         if (first_ok) begin
            grant <= 3'b001 << first_idx;
            ptr   <= wrap3(first_idx);
         end
      end else if ((req & grant) == 3'b000) begin
         grant <= 3'b000;
         hold  <= '0;
      end else if (hold_inc == HOLD && next_ok) begin
         grant <= 3'b001 << next_idx;
         ptr   <= wrap3(next_idx);
         hold  <= '0;
      end else begin
         hold <= hold_inc;
      end
   end

   state_t        st, st_n;
   logic [31:0]   cnt, cnt_n;
   logic [IW-1:0] idx, idx_n;
   logic          entry;
   logic          lit_n;
   logic          bit_on;
   logic [3:0]    code;
   logic [6:0]    cur;
   logic [6:0]    shown;

   always_comb begin
      st_n  = st;
      cnt_n = cnt + 32'd1;
      idx_n = idx;
      entry = 1'b0;
      if (st == SHOW && cnt == SHOW_LAST) begin
         st_n  = BLANK;
         cnt_n = '0;
      end else if (st == BLANK && cnt == BLANK_LAST) begin
         st_n  = SHOW;
         cnt_n = '0;
         entry = 1'b1;
         idx_n = (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end
   end

   // owner and digit code are latched at SHOW entry from the current grant
   always_comb begin
      code   = 4'hF;
      bit_on = 1'b0;
      unique case (1'b1)
         grant[0]: begin
            code   = data0[4*idx_n +: 4];
            bit_on = mask0[idx_n];
         end
         grant[1]: begin
            code   = data1[4*idx_n +: 4];
            bit_on = mask1[idx_n];
         end
         grant[2]: begin
            code   = data2[4*idx_n +: 4];
            bit_on = mask2[idx_n];
         end
         default: ;
      endcase
   end

   assign shown = entry ? (bit_on ? dec(code) : 7'h00) : cur;

`ifdef SEG_DIM_EN
   logic [35:0] lim;
   assign lim   = (36'(SCAN_DIV) * {32'd0, duty}) >> 4;
   assign lit_n = {4'd0, cnt_n} < lim;
`else
   assign lit_n = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= BLANK;
         cnt        <= '0;
         idx        <= LAST_IDX;
         cur        <= 7'h00;
         seg        <= 7'h00;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         st         <= st_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         cur        <= shown;
         frame_done <= st_n == BLANK && cnt_n == BLANK_LAST &&
                       idx_n == LAST_IDX;
         if (st_n == SHOW && lit_n) begin
            seg       <= shown;
            digit_sel <= NUM_DIGITS'(1) << idx_n;
         end else begin
            seg       <= 7'h00;
            digit_sel <= '0;
         end
      end
   end

endmodule
